// File: rtl/enemy_hit_detect.sv
// Per-frame bullet vs. enemy-formation hit test: serial scan, first hit is killed and scored.
// Latency: enemy k tested k+1 cycles after fsync; hit/bullet_kill registered, worst case N+1 cycles.
// Backpressure: none; fsync outside IDLE is ignored and wave_restart preempts everything.
module enemy_hit_detect #(
    parameter int ENEMY_COLS = 8,
    parameter int ENEMY_ROWS = 4,
    parameter int ENEMY_W    = 16,
    parameter int ENEMY_H    = 12,
    parameter int PITCH_X    = 24,
    parameter int PITCH_Y    = 20,
    parameter int POINTS     = 10
) (
    input  logic                               pixel_clk,
    input  logic                               rst_n,
    input  logic                               fsync,
    input  logic                               wave_restart,
    input  logic                               bullet_active,
    input  logic signed [11:0]                 bullet_left,
    input  logic signed [11:0]                 bullet_right,
    input  logic signed [11:0]                 bullet_top,
    input  logic signed [11:0]                 bullet_bottom,
    input  logic signed [11:0]                 form_x,
    input  logic signed [11:0]                 form_y,
    output logic [ENEMY_ROWS*ENEMY_COLS-1:0]   alive,
    output logic                               hit,
    output logic [5:0]                         hit_idx,
    output logic                               bullet_kill,
    output logic [15:0]                        score,
    output logic                               wave_clear,
    output logic                               scan_busy
);

    localparam int N    = ENEMY_ROWS * ENEMY_COLS;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = (ENEMY_COLS > 1) ? $clog2(ENEMY_COLS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(N - 1);
    localparam logic [CW-1:0]     COL_LAST = CW'(ENEMY_COLS - 1);
    localparam logic signed [12:0] W_M1    = 13'(ENEMY_W - 1);
    localparam logic signed [12:0] H_M1    = 13'(ENEMY_H - 1);
    localparam logic signed [12:0] PX      = 13'(PITCH_X);
    localparam logic signed [12:0] PY      = 13'(PITCH_Y);

    logic [1:0]            state_q, state_d;
    logic [N-1:0]          alive_q, alive_d;
    logic                  hit_q, hit_d;
    logic [5:0]            hit_idx_q, hit_idx_d;
    logic [15:0]           score_q, score_d;
    logic                  wave_clear_q, wave_clear_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [CW-1:0]         col_q, col_d;
    logic signed [12:0]    bl_q, bl_d, br_q, br_d, bt_q, bt_d, bb_q, bb_d;
    logic signed [12:0]    sx_q, sx_d, el_q, el_d, et_q, et_d;

    logic signed [12:0]    er, eb;
    logic                  overlap;
    logic [16:0]           score_sum;

    // el_q/et_q track the current enemy's top-left corner as running sums.
    assign er        = el_q + W_M1;
    assign eb        = et_q + H_M1;
    assign overlap   = alive_q[idx_q] && (bl_q <= er) && (br_q >= el_q) &&
                       (bt_q <= eb) && (bb_q >= et_q);
    assign score_sum = {1'b0, score_q} + 17'(POINTS);

    always_comb begin
        state_d      = state_q;
        alive_d      = alive_q;
        hit_d        = 1'b0;
        hit_idx_d    = hit_idx_q;
        score_d      = score_q;
        idx_d        = idx_q;
        col_d        = col_q;
        bl_d         = bl_q;
        br_d         = br_q;
        bt_d         = bt_q;
        bb_d         = bb_q;
        sx_d         = sx_q;
        el_d         = el_q;
        et_d         = et_q;
        wave_clear_d = (alive_q == '0);

        case (state_q)
            ST_IDLE: begin
                if (fsync && bullet_active) begin
                    bl_d    = {bullet_left[11], bullet_left};
                    br_d    = {bullet_right[11], bullet_right};
                    bt_d    = {bullet_top[11], bullet_top};
                    bb_d    = {bullet_bottom[11], bullet_bottom};
                    sx_d    = {form_x[11], form_x};
                    el_d    = {form_x[11], form_x};
                    et_d    = {form_y[11], form_y};
                    idx_d   = '0;
                    col_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (overlap) begin
                    alive_d[idx_q] = 1'b0;
                    hit_d          = 1'b1;
                    hit_idx_d      = 6'(idx_q);
                    score_d        = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    state_d        = ST_DONE;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        el_d  = sx_q;
                        et_d  = et_q + PY;
                    end else begin
                        col_d = col_q + CW'(1);
                        el_d  = el_q + PX;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A restart beats a same-cycle kill: formation revived, no pulse, score untouched.
        if (wave_restart) begin
            alive_d   = '1;
            hit_d     = 1'b0;
            hit_idx_d = hit_idx_q;
            score_d   = score_q;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alive_q      <= '1;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            score_q      <= '0;
            wave_clear_q <= 1'b0;
            idx_q        <= '0;
            col_q        <= '0;
            bl_q         <= '0;
            br_q         <= '0;
            bt_q         <= '0;
            bb_q         <= '0;
            sx_q         <= '0;
            el_q         <= '0;
            et_q         <= '0;
        end else begin
            state_q      <= state_d;
            alive_q      <= alive_d;
            hit_q        <= hit_d;
            hit_idx_q    <= hit_idx_d;
            score_q      <= score_d;
            wave_clear_q <= wave_clear_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            bl_q         <= bl_d;
            br_q         <= br_d;
            bt_q         <= bt_d;
            bb_q         <= bb_d;
            sx_q         <= sx_d;
            el_q         <= el_d;
            et_q         <= et_d;
        end
    end

    assign alive       = alive_q;
    assign hit         = hit_q;
    assign hit_idx     = hit_idx_q;
    assign bullet_kill = hit_q;
    assign score       = score_q;
    assign wave_clear  = wave_clear_q;
    assign scan_busy   = (state_q == ST_SCAN);

endmodule
